// File: rtl/bcd_digit_entry_pkg.sv
// Shared constants and types for the keypad BCD entry stage.
package bcd_digit_entry_pkg;

  // Number of BCD digits in the packed operand
  localparam int unsigned BCD_DIGITS = 4;

  // Key codes; 0x0-0x9 are digits, 0xD-0xF are ignored
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_BACK  = 4'hC;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StEntry = 2'd1,
    StDone  = 2'd2
  } entry_state_e;

  // Mask with one all-ones nibble per accepted digit, units nibble first
  function automatic logic [15:0] digit_mask(int unsigned n);
    logic [15:0] m;
    m = '0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (i < n) m[4*i +: 4] = 4'hF;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_digit_entry_key_strobe_sync.sv
// Synchronizes an asynchronous key_valid level, detects its rising edge and
// registers key_code alongside so the code stays aligned with the strobe.
// Used only when KEY_SYNC_EN is defined.
module key_strobe_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic       key_valid_o,
  output logic [3:0] key_code_o
);

  logic       sync1_q, sync2_q, prev_q;
  logic [3:0] code1_q, code2_q;

  // Two-flop synchronizer, edge-history flop and matching code pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      code1_q <= 4'h0;
      code2_q <= 4'h0;
    end else begin
      sync1_q <= key_valid_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      code1_q <= key_code_i;
      code2_q <= code1_q;
    end
  end

  // A held level produces exactly one strobe
  always_comb begin
    key_valid_o = sync2_q & ~prev_q;
    key_code_o  = code2_q;
  end

endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad entry stage: accumulates decimal keys into a packed BCD operand,
// MSD first, with clear/backspace and a valid/ack handshake on completion.
// Optional macro KEY_SYNC_EN: synchronize and edge-detect key_valid
// (3-cycle key latency instead of 1).
module bcd_digit_entry
  import bcd_digit_entry_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] num_BCD,
  output logic [2:0]  digit_count,
  output logic        num_valid,
  input  logic        num_ack,
  output logic        key_reject
);

  localparam logic [15:0] DigitMask = digit_mask(MAX_DIGITS);
  localparam logic [2:0]  MaxCount  = 3'(MAX_DIGITS);

  logic       kv;
  logic [3:0] kc;

`ifdef KEY_SYNC_EN
  key_strobe_sync u_key_strobe_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid_i (key_valid),
    .key_code_i  (key_code),
    .key_valid_o (kv),
    .key_code_o  (kc)
  );
`else
  assign kv = key_valid;
  assign kc = key_code;
`endif

  entry_state_e state_q, state_d;
  logic [15:0]  num_q, num_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         reject_q, reject_d;
  logic         is_digit;

  assign is_digit = (kc <= 4'd9);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      num_q    <= 16'h0000;
      cnt_q    <= 3'd0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
    end
  end

  // Next-state logic for key handling and handshake
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    reject_d = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (kv) begin
          if (is_digit) begin
            num_d   = {12'h000, kc} & DigitMask;
            cnt_d   = 3'd1;
            state_d = StEntry;
          end else if (kc == KEY_ENTER) begin
            num_d   = 16'h0000;
            valid_d = 1'b1;
            state_d = StDone;
          end else if (kc == KEY_BACK) begin
            reject_d = 1'b1;
          end
        end
      end
      StEntry: begin
        if (kv) begin
          if (is_digit) begin
            if (cnt_q < MaxCount) begin
              num_d = {num_q[11:0], kc} & DigitMask;
              cnt_d = cnt_q + 3'd1;
            end else begin
              reject_d = 1'b1;
            end
          end else if (kc == KEY_BACK) begin
            num_d = {4'h0, num_q[15:4]};
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = StEmpty;
          end else if (kc == KEY_CLEAR) begin
            num_d   = 16'h0000;
            cnt_d   = 3'd0;
            state_d = StEmpty;
          end else if (kc == KEY_ENTER) begin
            valid_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // A key arriving together with the ack is dropped without a reject
        if (num_ack) begin
          valid_d = 1'b0;
          num_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = StEmpty;
        end else if (kv && (kc <= KEY_BACK)) begin
          reject_d = 1'b1;
        end
      end
      default: begin
        state_d = StEmpty;
        num_d   = 16'h0000;
        cnt_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign num_BCD     = num_q;
  assign digit_count = cnt_q;
  assign num_valid   = valid_q;
  assign key_reject  = reject_q;

endmodule

// File: doc/bcd_digit_entry.md
Name: bcd_digit_entry

Overview:
Sequential keypad-entry stage that sits directly upstream of the calculator's BCD-to-binary converter. It accumulates decimal key presses into a 4-digit packed BCD operand, most-significant digit first. It supports clear and backspace, then presents the finished operand through a valid/ack handshake. Its num_BCD output drives the converter's 16-bit BCD input directly.

Parameters:
MAX_DIGITS, 4, maximum digits accepted (legal range 1..4); further digit keys are rejected.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  one-cycle strobe: key_code is valid this cycle.
key_code  input  4  0x0-0x9 digit, 0xA enter, 0xB clear, 0xC backspace, 0xD-0xF ignored.
num_BCD  output  16  packed BCD operand; units in [3:0], thousands in [15:12].
digit_count  output  3  digits currently held (0..MAX_DIGITS).
num_valid  output  1  operand complete, held until acknowledged.
num_ack  input  1  consumer accepts operand; sampled only while num_valid=1.
key_reject  output  1  one-cycle pulse when a key is refused.

Behaviour:
- Reset (async assert, sync release) forces these values:
  - num_BCD=0, digit_count=0, num_valid=0, key_reject=0, state=EMPTY.
- FSM states: EMPTY, ENTRY, DONE. Keys act only when key_valid=1; response is registered with 1-cycle latency.
- EMPTY:
  - Digit d: num_BCD={12'h000,d}, count=1, go to ENTRY. Leading zeros are counted as digits.
  - Enter: num_BCD=0, num_valid=1, go to DONE (empty entry = operand 0).
  - Clear: no change, no reject.
  - Backspace: key_reject pulse.
- ENTRY:
  - Digit while count<MAX_DIGITS: num_BCD={num_BCD[11:0],d}, count+1.
  - Digit while count==MAX_DIGITS: key_reject pulse; value unchanged.
  - Backspace: num_BCD={4'h0,num_BCD[15:4]}, count-1; go to EMPTY if count becomes 0.
  - Clear: num_BCD=0, count=0, go to EMPTY.
  - Enter: num_valid=1, go to DONE.
- DONE:
  - num_BCD and digit_count are frozen.
  - num_ack=1: next cycle num_valid=0, num_BCD=0, count=0, state=EMPTY.
  - Any key while in DONE: key_reject pulse, ignored (including clear). Exception: a key in the same cycle as num_ack is ignored without reject.
- Codes 0xD-0xF: ignored silently in every state.
- num_ack outside DONE: ignored.
- num_BCD always holds legal BCD nibbles (each <=9); the upper (4-MAX_DIGITS) nibbles always read 0.
- Reset asserted mid-entry or in DONE: immediate return to reset values; a pending operand is discarded.

Optional Feature:
Macro KEY_SYNC_EN.
- Defined: key_valid passes through a 2-flop synchronizer plus a rising-edge detector, and key_code is registered alongside it. A level held for N cycles counts as one key. Key-to-output latency becomes 3 cycles.
- Undefined: key_valid is trusted as a synchronous 1-cycle strobe, with 1-cycle latency.

Decomposition:
- Shared package holds:
  - key code constants: KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_BACK=4'hC.
  - state encoding typedef: EMPTY=2'd0, ENTRY=2'd1, DONE=2'd2.
  - BCD_DIGITS=4.
- One natural sub-module, key_strobe_sync: the synchronizer/edge detector, instantiated only under KEY_SYNC_EN.

Test Plan:
1. Keys 1,2,3,4,enter -> num_BCD=16'h1234, count=4, num_valid=1. Hold until num_ack, then num_BCD=0, state EMPTY.
2. Keys 9,8,7,6,5 -> fifth key gives key_reject pulse, num_BCD=16'h9876. Backspace -> 16'h0987, count=3.
3. Keys 4,2,clear,7,enter -> num_BCD=16'h0007, num_valid=1. Digit key while DONE -> key_reject, value unchanged.
4. Enter from EMPTY -> num_valid=1, num_BCD=0. Backspace from EMPTY -> key_reject, no state change.
5. rst_n low for 1 cycle mid-entry after keys 5,6 -> all outputs 0 asynchronously; next digit 3 -> 16'h0003.
6. MAX_DIGITS=2: keys 1,2,3 -> reject on 3, num_BCD=16'h0012. With KEY_SYNC_EN, key_valid held 5 cycles -> exactly one digit captured.
